// File: rtl/calc_arb_pkg.sv
// rtl/calc_arb_pkg.sv - shared constants and types for the two-port calculator arbiter
package calc_arb_pkg;

  localparam int CALC_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_EXEC = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/calc_iter_core.sv
// rtl/calc_iter_core.sv - iterative add/sub/multiply/divide engine, one step per cycle
module calc_iter_core
  import calc_arb_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W:0]   res,
  output logic         flag,
  output logic         err
);

  logic           run;
  logic [2*W-1:0] acc;
  logic [W-1:0]   cnt;
  logic [W-1:0]   q;
  logic [W:0]     res_n;
  logic           flag_n;
  logic           err_n;

  // cnt doubles as the multiply down-counter and the divide remainder.
  always_comb begin
    done   = 1'b0;
    res_n  = '0;
    flag_n = 1'b0;
    err_n  = 1'b0;
    case (op)
      OP_ADD: begin
        done   = run;
        res_n  = {1'b0, cnt} + {1'b0, b};
        flag_n = res_n[W];
      end
      OP_SUB: begin
        done   = run;
        res_n  = {1'b0, cnt - b};
        flag_n = (cnt < b);
      end
      OP_MUL: begin
        done   = run && (cnt == '0);
        res_n  = acc[W:0];
        flag_n = |acc[2*W-1:W];
      end
      default: begin
        if (b == '0) begin
          done   = run;
          flag_n = 1'b1;
          err_n  = 1'b1;
        end else begin
          done   = run && (cnt < b);
          res_n  = {1'b0, q};
          flag_n = (cnt != '0);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run  <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      q    <= '0;
      res  <= '0;
      flag <= 1'b0;
      err  <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      acc <= '0;
      cnt <= a;
      q   <= '0;
    end else if (run) begin
      if (done) begin
        run  <= 1'b0;
        res  <= res_n;
        flag <= flag_n;
        err  <= err_n;
      end else if (op == OP_MUL) begin
        acc <= acc + {{W{1'b0}}, b};
        cnt <= cnt - W'(1);
      end else if (op == OP_DIV) begin
        cnt <= cnt - b;
        q   <= q + W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// rtl/calc_arbiter.sv - round-robin arbiter sharing one iterative calculator between two requesters
module calc_arbiter
  import calc_arb_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic [1:0]   Op0,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  output logic         Ack0,
  output logic         Done0,
  input  logic         Req1,
  input  logic [1:0]   Op1,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  output logic         Ack1,
  output logic         Done1,
  output logic [W:0]   Res,
  output logic         Flag,
  output logic         Err,
  output logic         Busy
);

  state_t       state;
  logic         gnt;
  logic         last;
  logic         win;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         core_done;

  // A tie goes to whoever was not served last; a lone requester always wins.
  assign win = (Req0 && Req1) ? ~last : Req1;

  calc_iter_core #(.W(W)) u_core (
    .Clk   (Clk),
    .Reset (Reset),
    .start (state == ST_LOAD),
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .done  (core_done),
    .res   (Res),
    .flag  (Flag),
    .err   (Err)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      Ack0  <= 1'b0;
      Ack1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req0 || Req1) begin
            state <= ST_LOAD;
            Busy  <= 1'b1;
            gnt   <= win;
            op_q  <= win ? Op1 : Op0;
            a_q   <= win ? A1 : A0;
            b_q   <= win ? B1 : B0;
            Ack0  <= ~win;
            Ack1  <= win;
          end
        end
        ST_LOAD: begin
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (core_done) begin
            state <= ST_DONE;
            Done0 <= ~gnt;
            Done1 <= gnt;
          end
        end
        ST_DONE: begin
          Done0 <= 1'b0;
          Done1 <= 1'b0;
          last  <= gnt;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Done0 <= 1'b0;
          Done1 <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb/tb_calc_arbiter.sv - directed vector bench for calc_arbiter
module tb_calc_arbiter;
  import calc_arb_pkg::*;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [1:0]   Op0 = 2'b00, Op1 = 2'b00;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         Ack0, Done0, Ack1, Done1, Flag, Err, Busy;
  logic [W:0]   Res;

  int n_tests = 0;
  int n_fail  = 0;

  calc_arbiter #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0), .Ack0(Ack0), .Done0(Done0),
    .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1), .Ack1(Ack1), .Done1(Done1),
    .Res(Res), .Flag(Flag), .Err(Err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int           id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           e;
    logic [W:0]   res;
    logic         flag;
    logic         err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic on, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      Req0 = on; Op0 = op; A0 = a; B0 = b;
    end else begin
      Req1 = on; Op1 = op; A1 = a; B1 = b;
    end
  endtask

  task automatic wait_done(input int id, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 400 && cyc == 0; i++) begin
      @(negedge Clk);
      if ((id == 0) ? Done0 : Done1) cyc = i;
    end
  endtask

  task automatic serve(input vec_t v, input string tag);
    int   dcyc;
    logic wrong;
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    @(negedge Clk);
    check({tag, " ack"}, 32'((v.id == 0) ? Ack0 : Ack1), 32'd1);
    check({tag, " other ack"}, 32'((v.id == 0) ? Ack1 : Ack0), 32'd0);
    // Operands scrambled after Ack must not disturb the result.
    set_req(v.id, 1'b0, ~v.op, ~v.a, ~v.b);
    dcyc  = 0;
    wrong = 1'b0;
    for (int i = 2; i <= v.e + 22 && dcyc == 0; i++) begin
      @(negedge Clk);
      if (((v.id == 0) ? Done1 : Done0) || Ack0 || Ack1) wrong = 1'b1;
      if ((v.id == 0) ? Done0 : Done1) dcyc = i;
    end
    check({tag, " done latency"}, 32'(dcyc), 32'(v.e + 2));
    check({tag, " wrong port"}, 32'(wrong), 32'd0);
    check({tag, " busy"}, 32'(Busy), 32'd1);
    check({tag, " res"}, 32'(Res), 32'(v.res));
    check({tag, " flag"}, 32'(Flag), 32'(v.flag));
    check({tag, " err"}, 32'(Err), 32'(v.err));
    @(negedge Clk);
    check({tag, " idle busy"}, 32'(Busy), 32'd0);
    repeat (2) @(negedge Clk);
    check({tag, " res hold"}, 32'(Res), 32'(v.res));
  endtask

  initial begin
    int got, dcyc, acyc, early, ndone;
    vecs[0] = '{0, OP_ADD, 16'hFFFF, 16'h0001, 1,   17'h10000, 1'b1, 1'b0};
    vecs[1] = '{1, OP_MUL, 16'd3,    16'd4,    4,   17'd12,    1'b0, 1'b0};
    vecs[2] = '{1, OP_MUL, 16'h0100, 16'h0100, 257, 17'h10000, 1'b1, 1'b0};
    vecs[3] = '{0, OP_DIV, 16'd7,    16'd2,    4,   17'd3,     1'b1, 1'b0};
    vecs[4] = '{0, OP_DIV, 16'd8,    16'd0,    1,   17'd0,     1'b1, 1'b1};
    vecs[5] = '{0, OP_SUB, 16'd5,    16'd3,    1,   17'd2,     1'b0, 1'b0};
    vecs[6] = '{1, OP_SUB, 16'd3,    16'd5,    1,   17'h0FFFE, 1'b1, 1'b0};
    vecs[7] = '{1, OP_MUL, 16'd0,    16'd9,    1,   17'd0,     1'b0, 1'b0};
    vecs[8] = '{0, OP_DIV, 16'd9,    16'd3,    4,   17'd3,     1'b0, 1'b0};
    vecs[9] = '{1, OP_ADD, 16'h1234, 16'h4321, 1,   17'h05555, 1'b0, 1'b0};

    // Reset state, then both requesters contend from the first IDLE cycle.
    repeat (2) @(negedge Clk);
    check("reset res", 32'(Res), 32'd0);
    check("reset outs", 32'({Ack0, Ack1, Done0, Done1, Busy, Flag, Err}), 32'd0);
    set_req(0, 1'b1, OP_SUB, 16'd5, 16'd3);
    set_req(1, 1'b1, OP_SUB, 16'd3, 16'd5);
    Reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      got = -1;
      for (int i = 0; i < 20 && got < 0; i++) begin
        @(negedge Clk);
        if (Ack0 && Ack1) got = 2;
        else if (Ack0) got = 0;
        else if (Ack1) got = 1;
      end
      check($sformatf("rr grant %0d", s), 32'(got), 32'(s % 2));
      wait_done(s % 2, dcyc);
      check($sformatf("rr done %0d", s), 32'(dcyc), 32'd2);
      check($sformatf("rr other done %0d", s), 32'((s % 2 == 0) ? Done1 : Done0), 32'd0);
      check($sformatf("rr res %0d", s), 32'(Res), (s % 2 == 0) ? 32'd2 : 32'h0FFFE);
      check($sformatf("rr flag %0d", s), 32'(Flag), 32'(s % 2));
      if (s == 3) begin
        Req0 = 1'b0;
        Req1 = 1'b0;
      end
    end
    repeat (3) @(negedge Clk);
    check("rr drained", 32'(Busy), 32'd0);

    foreach (vecs[i]) serve(vecs[i], $sformatf("vec%0d", i));

    // Requester 1 arrives mid-service of requester 0 and must wait.
    set_req(0, 1'b1, OP_MUL, 16'd10, 16'd2);
    @(negedge Clk);
    check("late ack0", 32'(Ack0), 32'd1);
    set_req(0, 1'b0, OP_MUL, 16'd10, 16'd2);
    @(negedge Clk);
    set_req(1, 1'b1, OP_ADD, 16'd1, 16'd2);
    dcyc = 0; acyc = 0; early = 0;
    for (int i = 1; i <= 60 && acyc == 0; i++) begin
      @(negedge Clk);
      if (Done0) dcyc = i;
      if (Ack1) begin
        acyc = i;
        if (dcyc == 0) early = 1;
      end
    end
    check("late no early ack1", 32'(early), 32'd0);
    check("late res mul", 32'(Res), 32'd20);
    check("late ack1 gap", 32'(acyc - dcyc), 32'd2);
    Req1 = 1'b0;
    wait_done(1, dcyc);
    check("late done1", 32'(dcyc), 32'd2);
    check("late res add", 32'(Res), 32'd3);
    @(negedge Clk);

    // Reset mid-EXEC: requester 0 was served last, so only reset gives it the tie.
    serve('{0, OP_ADD, 16'h0010, 16'h0020, 1, 17'h00030, 1'b0, 1'b0}, "pre");
    set_req(0, 1'b1, OP_MUL, 16'd50, 16'd3);
    @(negedge Clk);
    set_req(0, 1'b0, OP_MUL, 16'd50, 16'd3);
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("mid reset res", 32'(Res), 32'd0);
    check("mid reset outs", 32'({Ack0, Ack1, Done0, Done1, Busy, Flag, Err}), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Done0 || Done1 || Busy) ndone++;
    end
    check("no done after reset", 32'(ndone), 32'd0);
    set_req(0, 1'b1, OP_ADD, 16'd2, 16'd2);
    set_req(1, 1'b1, OP_ADD, 16'd7, 16'd8);
    @(negedge Clk);
    check("tie after reset", 32'({Ack0, Ack1}), 32'b10);
    Req0 = 1'b0;
    wait_done(0, dcyc);
    check("tie res", 32'(Res), 32'd4);
    got = -1;
    for (int i = 0; i < 10 && got < 0; i++) begin
      @(negedge Clk);
      if (Ack1) got = i;
    end
    check("req1 after reset ack", 32'(got), 32'd1);
    Req1 = 1'b0;
    wait_done(1, dcyc);
    check("req1 after reset done", 32'(dcyc), 32'd2);
    check("req1 after reset res", 32'(Res), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
